mem_bus_target: RTL and testbench

- Memory-side responder for the CPU's instruction/operand bus (addr, rd, wr, data_in, data_out).
- Holds a 32x8 storage array and services one bus request at a time, with a programmable number of wait states.
- Adds a `ready` handshake so the controller can be stretched for slow memory.
- Provides a side preload port so a bench or boot loader can write the program image while the bus is idle.

---
 rtl/mem_bus_target.sv | 144 ++++++++++++++
 tb/tb_mem_bus_target.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_target.sv
// Single-port 2**ADDR_W x DATA_W bus target with programmable wait states, ready handshake and side preload port.
// Optional even-parity protection per word is enabled by defining PARITY_CHECK_EN.
module mem_bus_target #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              req_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_drop,
    output logic              par_err
`ifdef PARITY_CHECK_EN
    ,
    input  logic              parity_inject
`endif
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_write;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_idle;
    logic              accept;
    logic              complete;
    logic              preload;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    // With zero wait states the access completes on the accepting edge, so it uses the live bus inputs.
    always_comb begin
        in_idle   = (state == S_IDLE);
        accept    = in_idle && (rd ^ wr);
        complete  = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));
        preload   = in_idle && load_en && !rd && !wr;
        acc_write = in_idle ? wr      : lat_write;
        acc_addr  = in_idle ? addr    : lat_addr;
        acc_data  = in_idle ? data_in : lat_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            data_out  <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            req_err   <= 1'b0;
            load_drop <= 1'b0;
            // NOTE: the storage array must read back as zero after reset, so it is reset word by word
            // like ordinary flops; this rules out mapping it onto a RAM macro.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            ready     <= complete;
            req_err   <= in_idle && rd && wr;
            load_drop <= load_en && !preload;

            if (preload) mem[load_addr] <= load_data;
            if (complete) begin
                if (acc_write) mem[acc_addr] <= acc_data;
                else           data_out      <= mem[acc_addr];
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr  <= addr;
                        lat_data  <= data_in;
                        lat_write <= wr;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_mem [DEPTH];
    logic lat_inject;
    logic acc_inject;

    assign acc_inject = in_idle ? parity_inject : lat_inject;

    // Parity of an all-zero word is 0, so clearing the parity bits keeps reset state consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_inject <= 1'b0;
            par_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
        end else begin
            par_err <= 1'b0;
            if (accept)  lat_inject         <= parity_inject;
            if (preload) par_mem[load_addr] <= ^load_data;
            if (complete) begin
                if (acc_write) par_mem[acc_addr] <= (^acc_data) ^ acc_inject;
                else           par_err           <= (^mem[acc_addr]) != par_mem[acc_addr];
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_target.sv
// Self-checking bench for mem_bus_target: directed test-plan sequences plus randomized traffic
// compared every cycle against a cycle-count based behavioural model.
module tb_mem_bus_target;

    localparam int W_MAIN = 2;

    logic       clk;
    logic       rst;
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ready;
    logic       busy;
    logic       req_err;
    logic       load_en;
    logic [4:0] load_addr;
    logic [7:0] load_data;
    logic       load_drop;
    logic       par_err;
    logic       pinj;

    logic [4:0] z_addr;
    logic       z_rd;
    logic       z_wr;
    logic [7:0] z_data_in;
    logic [7:0] z_data_out;
    logic       z_ready;
    logic       z_busy;
    logic       z_req_err;
    logic       z_load_en;
    logic [4:0] z_load_addr;
    logic [7:0] z_load_data;
    logic       z_load_drop;
    logic       z_par_err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    mem_bus_target #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(W_MAIN)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
        .data_out(data_out), .ready(ready), .busy(busy), .req_err(req_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_drop(load_drop), .par_err(par_err)
`ifdef PARITY_CHECK_EN
        , .parity_inject(pinj)
`endif
    );

    mem_bus_target #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .addr(z_addr), .rd(z_rd), .wr(z_wr), .data_in(z_data_in),
        .data_out(z_data_out), .ready(z_ready), .busy(z_busy), .req_err(z_req_err),
        .load_en(z_load_en), .load_addr(z_load_addr), .load_data(z_load_data),
        .load_drop(z_load_drop), .par_err(z_par_err)
`ifdef PARITY_CHECK_EN
        , .parity_inject(1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a request accepted at edge n completes at edge n+W, the target is idle again
    // two edges after completion, and busy covers edges n..n+W.
    int         cyc = 0;
    int         resp_edge = -100;
    logic [7:0] mmem [32];
    bit         mbad [32];
    bit         op_wr;
    bit         op_inj;
    logic [4:0] op_addr;
    logic [7:0] op_data;
    logic [7:0] exp_dout = '0;
    bit         exp_ready = 0, exp_busy = 0, exp_req_err = 0, exp_load_drop = 0, exp_par_err = 0;

    always @(posedge clk) begin
        bit idle;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mmem[i] = '0;
                mbad[i] = 0;
            end
            resp_edge = -100;
            exp_dout = '0; exp_ready = 0; exp_busy = 0;
            exp_req_err = 0; exp_load_drop = 0; exp_par_err = 0;
        end else begin
            idle = (cyc >= resp_edge + 2);
            exp_ready = 0; exp_req_err = 0; exp_par_err = 0;
            exp_load_drop = load_en && !(idle && !rd && !wr);
            if (idle) begin
                if (rd && wr) exp_req_err = 1;
                else if (rd || wr) begin
                    resp_edge = cyc + W_MAIN;
                    op_wr = wr; op_addr = addr; op_data = data_in; op_inj = pinj;
                end else if (load_en) begin
                    mmem[load_addr] = load_data;
                    mbad[load_addr] = 0;
                end
            end
            if (cyc == resp_edge) begin
                exp_ready = 1;
                if (op_wr) begin
                    mmem[op_addr] = op_data;
                    mbad[op_addr] = op_inj;
                end else begin
                    exp_dout    = mmem[op_addr];
                    exp_par_err = mbad[op_addr];
                end
            end
            exp_busy = (cyc <= resp_edge);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready",     ready,     exp_ready);
            check("m_busy",      busy,      exp_busy);
            check("m_data_out",  data_out,  exp_dout);
            check("m_req_err",   req_err,   exp_req_err);
            check("m_load_drop", load_drop, exp_load_drop);
            check("m_par_err",   par_err,   exp_par_err);
        end
    end

    task automatic idle_inputs();
        rd = 0; wr = 0; load_en = 0; pinj = 0;
    endtask

    // Called at a negedge with the target idle; returns at the negedge after the response cycle.
    task automatic bus_op(input bit is_wr, input logic [4:0] a, input logic [7:0] d, input bit inj,
                          output int lat, output int bcnt, output logic [7:0] got, output logic got_perr);
        rd = !is_wr; wr = is_wr; addr = a; data_in = d; pinj = inj;
        @(negedge clk);
        rd = 0; wr = 0; pinj = 0;
        lat = 1; bcnt = int'(busy);
        while (!ready && lat < 20) begin
            @(negedge clk);
            lat++;
            bcnt += int'(busy);
        end
        got = data_out;
        got_perr = par_err;
        @(negedge clk);
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        load_en = 1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 0;
    endtask

    initial begin
        int lat, bcnt, r;
        logic [7:0] got;
        logic perr;

        rst = 1; addr = '0; data_in = '0; load_addr = '0; load_data = '0;
        idle_inputs();
        z_rd = 0; z_wr = 0; z_addr = '0; z_data_in = '0; z_load_en = 0; z_load_addr = '0; z_load_data = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 8'h00);
        rst = 0;
        @(negedge clk);

        for (int a = 0; a < 32; a++) begin
            bus_op(0, 5'(a), 8'h00, 0, lat, bcnt, got, perr);
            check("rd0_latency", lat, 3);
            check("rd0_busy_cycles", bcnt, 3);
            check("rd0_data", got, 8'h00);
        end

        preload(5'd5, 8'hA7);
        bus_op(0, 5'd5, 8'h00, 0, lat, bcnt, got, perr);
        check("pre_rd_data", got, 8'hA7);
        repeat (3) @(negedge clk);
        check("pre_rd_hold", data_out, 8'hA7);
        bus_op(1, 5'd5, 8'h3C, 0, lat, bcnt, got, perr);
        check("wr_lat", lat, 3);
        check("wr_keeps_dout", data_out, 8'hA7);
        bus_op(0, 5'd5, 8'h00, 0, lat, bcnt, got, perr);
        check("reread_data", got, 8'h3C);

        rd = 1; wr = 1; addr = 5'd9; data_in = 8'hFF;
        @(negedge clk);
        rd = 0; wr = 0;
        check("both_req_err", req_err, 1);
        check("both_busy", busy, 0);
        @(negedge clk);
        check("both_req_err_end", req_err, 0);
        bus_op(0, 5'd9, 8'h00, 0, lat, bcnt, got, perr);
        check("both_mem_same", got, 8'h00);

        rd = 1; addr = 5'd5;
        @(negedge clk);
        rd = 0;
        load_en = 1; load_addr = 5'd5; load_data = 8'h11;
        @(negedge clk);
        load_en = 0;
        check("busy_load_drop", load_drop, 1);
        repeat (4) @(negedge clk);
        rd = 1; addr = 5'd6; load_en = 1; load_addr = 5'd5; load_data = 8'h22;
        @(negedge clk);
        rd = 0; load_en = 0;
        check("same_cyc_load_drop", load_drop, 1);
        repeat (4) @(negedge clk);
        bus_op(0, 5'd5, 8'h00, 0, lat, bcnt, got, perr);
        check("drop_mem_same", got, 8'h3C);

        wr = 1; addr = 5'd12; data_in = 8'h99;
        @(negedge clk);
        wr = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        check("wait_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_rst_no_ready", ready, 0);
        end
        bus_op(0, 5'd12, 8'h00, 0, lat, bcnt, got, perr);
        check("wait_rst_discard", got, 8'h00);

        z_load_en = 1; z_load_addr = 5'd31; z_load_data = 8'h5A;
        @(negedge clk);
        z_load_en = 0; z_rd = 1; z_addr = 5'd31;
        @(negedge clk);
        z_rd = 0;
        check("z_ready", z_ready, 1);
        check("z_data", z_data_out, 8'h5A);
        check("z_busy", z_busy, 1);
        @(negedge clk);
        check("z_ready_end", z_ready, 0);
        check("z_busy_end", z_busy, 0);

`ifdef PARITY_CHECK_EN
        bus_op(1, 5'd20, 8'h81, 1, lat, bcnt, got, perr);
        bus_op(0, 5'd20, 8'h00, 0, lat, bcnt, got, perr);
        check("par_inj_err", perr, 1);
        check("par_inj_data", got, 8'h81);
        bus_op(1, 5'd20, 8'h81, 0, lat, bcnt, got, perr);
        bus_op(0, 5'd20, 8'h00, 0, lat, bcnt, got, perr);
        check("par_ok_err", perr, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom % 8);
            rd = (r < 2) || (r == 4);
            wr = (r == 2) || (r == 3) || (r == 4);
            addr = 5'($urandom);
            data_in = 8'($urandom);
            load_en = ($urandom % 4) == 0;
            load_addr = 5'($urandom);
            load_data = 8'($urandom);
`ifdef PARITY_CHECK_EN
            pinj = ($urandom % 4) == 0;
`endif
            rst = ($urandom % 400) == 0;
            @(negedge clk);
        end
        idle_inputs();
        rst = 0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
